// File: rtl/spif_reg_bank.sv
// spif_reg_bank: APB- and packet-accessible register bank with router/mapper tables and saturating counters.
module spif_reg_bank #(
    parameter int NUM_HREGS = 5,
    parameter int NUM_RREGS = 16,
    parameter int NUM_CREGS = 8,
    parameter int NUM_MREGS = 4,
    parameter bit CTR_COR   = 1'b0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      apb_psel_in,
    input  logic                      apb_penable_in,
    input  logic                      apb_pwrite_in,
    input  logic [39:0]               apb_paddr_in,
    input  logic [31:0]               apb_pwdata_in,
    output logic [31:0]               apb_prdata_out,
    output logic                      apb_pready_out,
    output logic                      apb_pslverr_out,
    input  logic [7:0]                prx_addr_in,
    input  logic [31:0]               prx_wdata_in,
    input  logic                      prx_en_in,
    input  logic                      prx_wr_in,
    output logic [31:0]               prx_rdata_out,
    output logic                      prx_rvld_out,
    input  logic                      prx_rrdy_in,
    output logic                      prx_rd_drop_out,
    input  logic [NUM_CREGS-1:0]      ctr_cnt_in,
    output logic                      hssl_stop_out,
    output logic [31:0]               mp_key_out,
    output logic [31:0]               reply_key_out,
    output logic [31:0]               input_wait_out,
    output logic [31:0]               output_wait_out,
    output logic [32*NUM_CREGS-1:0]   reg_ctr_out,
    output logic [32*NUM_RREGS-1:0]   reg_rt_key_out,
    output logic [32*NUM_RREGS-1:0]   reg_rt_mask_out,
    output logic [3*NUM_RREGS-1:0]    reg_rt_route_out,
    output logic [32*NUM_MREGS-1:0]   reg_mp_fmsk_out,
    output logic [5*NUM_MREGS-1:0]    reg_mp_fsft_out
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nx;
    logic [31:0] regs [8][16];
    logic [2:0] a_sec, p_sec, w_sec;
    logic [3:0] a_idx, p_idx, w_idx;
    logic [31:0] a_rdata, p_rdata, w_data;
    logic pkt_wr, pkt_rd, apb_go, apb_wr, apb_rd, w_en, cor_clr, err_q, unused;

    function automatic logic in_range(input logic [2:0] s, input logic [3:0] i);
        int lim;
        lim = s == 3'd0 ? NUM_HREGS : s <= 3'd3 ? NUM_RREGS : s == 3'd4 ? NUM_CREGS :
              s <= 3'd6 ? NUM_MREGS : 0;
        return 32'(i) < lim;
    endfunction

    // Narrow fields keep only their live bits so reads come back zero-extended.
    function automatic logic [31:0] wmask(input logic [2:0] s, input logic [3:0] i);
        return s == 3'd3 ? 32'h7 : s == 3'd6 ? 32'h1F : (s == 3'd0 && i == 4'd0) ? 32'h1 : '1;
    endfunction

    assign a_sec   = apb_paddr_in[8:6];
    assign a_idx   = apb_paddr_in[5:2];
    assign p_sec   = prx_addr_in[6:4];
    assign p_idx   = prx_addr_in[3:0];
    assign a_rdata = in_range(a_sec, a_idx) ? regs[a_sec][a_idx] : 32'hDEAD_BEEF;
    assign p_rdata = in_range(p_sec, p_idx) ? regs[p_sec][p_idx] : 32'hDEAD_BEEF;
    assign pkt_wr  = prx_en_in & prx_wr_in;
    assign pkt_rd  = prx_en_in & ~prx_wr_in;
    // Only an APB write collides with a packet write; an APB read still captures the old value.
    assign apb_go  = state == IDLE && apb_psel_in && apb_penable_in && !(apb_pwrite_in && pkt_wr);
    assign apb_wr  = apb_go & apb_pwrite_in;
    assign apb_rd  = apb_go & ~apb_pwrite_in;
    assign w_sec   = pkt_wr ? p_sec : a_sec;
    assign w_idx   = pkt_wr ? p_idx : a_idx;
    assign w_data  = pkt_wr ? prx_wdata_in : apb_pwdata_in;
    assign w_en    = (pkt_wr | apb_wr) & in_range(w_sec, w_idx);
    assign cor_clr = CTR_COR && apb_rd && a_sec == 3'd4 && in_range(a_sec, a_idx);
    assign unused  = ^{apb_paddr_in[39:9], apb_paddr_in[1:0], prx_addr_in[7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < 8; s++)
                for (int i = 0; i < 16; i++)
                    regs[s][i] <= '0;
            regs[0][2] <= 32'hFFFF_FD00;
            regs[0][3] <= 32'd32;
            regs[0][4] <= 32'd32;
        end else begin
            for (int i = 0; i < NUM_CREGS; i++)
                if (cor_clr && a_idx == 4'(i))
                    regs[4][i] <= {31'b0, ctr_cnt_in[i]};
                else if (ctr_cnt_in[i] && regs[4][i] != '1)
                    regs[4][i] <= regs[4][i] + 32'd1;
            if (w_en)
                regs[w_sec][w_idx] <= w_data & wmask(w_sec, w_idx);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = apb_go ? ACK : IDLE;
    end

    always_comb begin
        apb_pready_out  = state == ACK;
        apb_pslverr_out = state == ACK && err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            apb_prdata_out <= '0;
            err_q          <= 1'b0;
        end else if (apb_go) begin
            err_q <= !in_range(a_sec, a_idx);
            if (apb_rd) apb_prdata_out <= a_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prx_rvld_out    <= 1'b0;
            prx_rdata_out   <= '0;
            prx_rd_drop_out <= 1'b0;
        end else begin
            prx_rd_drop_out <= pkt_rd && prx_rvld_out && !prx_rrdy_in;
            if (pkt_rd && !(prx_rvld_out && !prx_rrdy_in)) begin
                prx_rvld_out  <= 1'b1;
                prx_rdata_out <= p_rdata;
            end else if (prx_rrdy_in) begin
                prx_rvld_out <= 1'b0;
            end
        end
    end

    assign hssl_stop_out   = regs[0][0][0];
    assign mp_key_out      = regs[0][1];
    assign reply_key_out   = regs[0][2];
    assign input_wait_out  = regs[0][3];
    assign output_wait_out = regs[0][4];

    for (genvar r = 0; r < NUM_RREGS; r++) begin : g_rt
        assign reg_rt_key_out[32*r+:32]  = regs[1][r];
        assign reg_rt_mask_out[32*r+:32] = regs[2][r];
        assign reg_rt_route_out[3*r+:3]  = regs[3][r][2:0];
    end
    for (genvar c = 0; c < NUM_CREGS; c++) begin : g_ctr
        assign reg_ctr_out[32*c+:32] = regs[4][c];
    end
    for (genvar m = 0; m < NUM_MREGS; m++) begin : g_mp
        assign reg_mp_fmsk_out[32*m+:32] = regs[5][m];
        assign reg_mp_fsft_out[5*m+:5]   = regs[6][m][4:0];
    end
endmodule

// File: tb/tb_spif_reg_bank.sv
// tb_spif_reg_bank: directed checks of the register bank with counters in clear-on-read mode.
module tb_spif_reg_bank;
    localparam int NC = 8, NR = 16, NM = 4;
    logic clk = 1'b0, resetn = 1'b0;
    logic apb_psel = 0, apb_penable = 0, apb_pwrite = 0;
    logic [39:0] apb_paddr = '0;
    logic [31:0] apb_pwdata = '0, apb_prdata;
    logic apb_pready, apb_pslverr;
    logic [7:0] prx_addr = '0;
    logic [31:0] prx_wdata = '0, prx_rdata;
    logic prx_en = 0, prx_wr = 0, prx_rvld, prx_rrdy = 0, prx_rd_drop;
    logic [NC-1:0] ctr_cnt = '0;
    logic hssl_stop;
    logic [31:0] mp_key, reply_key, input_wait, output_wait;
    logic [32*NC-1:0] reg_ctr;
    logic [32*NR-1:0] rt_key, rt_mask;
    logic [3*NR-1:0] rt_route;
    logic [32*NM-1:0] mp_fmsk;
    logic [5*NM-1:0] mp_fsft;
    int n_cmp = 0, n_bad = 0, drops = 0, lat;
    logic [31:0] rd;
    logic err;

    always #5 clk = ~clk;

    spif_reg_bank #(.CTR_COR(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .apb_psel_in(apb_psel), .apb_penable_in(apb_penable), .apb_pwrite_in(apb_pwrite),
        .apb_paddr_in(apb_paddr), .apb_pwdata_in(apb_pwdata), .apb_prdata_out(apb_prdata),
        .apb_pready_out(apb_pready), .apb_pslverr_out(apb_pslverr),
        .prx_addr_in(prx_addr), .prx_wdata_in(prx_wdata), .prx_en_in(prx_en), .prx_wr_in(prx_wr),
        .prx_rdata_out(prx_rdata), .prx_rvld_out(prx_rvld), .prx_rrdy_in(prx_rrdy),
        .prx_rd_drop_out(prx_rd_drop), .ctr_cnt_in(ctr_cnt), .hssl_stop_out(hssl_stop),
        .mp_key_out(mp_key), .reply_key_out(reply_key), .input_wait_out(input_wait),
        .output_wait_out(output_wait), .reg_ctr_out(reg_ctr), .reg_rt_key_out(rt_key),
        .reg_rt_mask_out(rt_mask), .reg_rt_route_out(rt_route), .reg_mp_fmsk_out(mp_fmsk),
        .reg_mp_fsft_out(mp_fsft)
    );

    always @(negedge clk) if (resetn && prx_rd_drop) drops++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb(input logic w, input logic [39:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e, output int l);
        apb_psel = 1; apb_penable = 0; apb_pwrite = w; apb_paddr = a; apb_pwdata = d;
        tick();
        apb_penable = 1;
        l = 0;
        do begin
            tick();
            l++;
        end while (!apb_pready && l < 6);
        r = apb_prdata;
        e = apb_pslverr;
        tick();
        apb_psel = 0; apb_penable = 0;
    endtask

    task automatic pkt_wr(input logic [7:0] a, input logic [31:0] d);
        prx_en = 1; prx_wr = 1; prx_addr = a; prx_wdata = d;
        tick();
        prx_en = 0; prx_wr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        chk("rst_stop", 32'(hssl_stop), 0);
        chk("rst_mpkey", mp_key, 0);
        chk("rst_replykey", reply_key, 32'hFFFF_FD00);
        chk("rst_inwait", input_wait, 32);
        chk("rst_outwait", output_wait, 32);
        chk("rst_pready", 32'(apb_pready), 0);
        chk("rst_prdata", apb_prdata, 0);
        chk("rst_rvld", 32'(prx_rvld), 0);
        chk("rst_rdata", prx_rdata, 0);
        chk("rst_drop", 32'(prx_rd_drop), 0);

        apb(1, 40'h04, 32'h1234, rd, err, lat);
        chk("wr_lat", lat, 1);
        chk("wr_err", 32'(err), 0);
        chk("wr_mpkey", mp_key, 32'h1234);
        chk("wr_pready_drop", 32'(apb_pready), 0);
        apb(0, 40'h04, 0, rd, err, lat);
        chk("rd_lat", lat, 1);
        chk("rd_data", rd, 32'h1234);

        apb(0, 40'h1C0, 0, rd, err, lat);
        chk("sec7_data", rd, 32'hDEAD_BEEF);
        chk("sec7_err", 32'(err), 1);
        apb(0, 40'h14, 0, rd, err, lat);
        chk("h5_data", rd, 32'hDEAD_BEEF);
        chk("h5_err", 32'(err), 1);
        apb(0, 40'h10, 0, rd, err, lat);
        chk("h4_data", rd, 32);
        chk("h4_err", 32'(err), 0);

        apb(1, 40'h150, 32'h1234, rd, err, lat);
        chk("fmsk4_err", 32'(err), 1);
        chk("fmsk3_untouched", mp_fmsk[96+:32], 0);
        apb(1, 40'h14C, 32'hF0F0, rd, err, lat);
        chk("fmsk3", mp_fmsk[96+:32], 32'hF0F0);

        pkt_wr(8'h35, 32'hFFFF_FFFE);
        chk("route5", 32'(rt_route[15+:3]), 6);
        apb(0, 40'hD4, 0, rd, err, lat);
        chk("route5_rd", rd, 6);
        apb(1, 40'h184, 32'h3F, rd, err, lat);
        chk("fsft1", 32'(mp_fsft[5+:5]), 32'h1F);
        pkt_wr(8'h00, 32'hFFFF_FFFF);
        chk("stop", 32'(hssl_stop), 1);
        apb(0, 40'h00, 0, rd, err, lat);
        chk("stop_rd", rd, 1);

        // APB write stalled by a coincident packet write
        apb_psel = 1; apb_penable = 0; apb_pwrite = 1; apb_paddr = 40'h48; apb_pwdata = 32'h5555;
        tick();
        apb_penable = 1;
        prx_en = 1; prx_wr = 1; prx_addr = 8'h12; prx_wdata = 32'hAAAA;
        tick();
        prx_en = 0; prx_wr = 0;
        chk("stall_pready", 32'(apb_pready), 0);
        chk("stall_key2_pkt", rt_key[64+:32], 32'hAAAA);
        tick();
        chk("stall_pready_late", 32'(apb_pready), 1);
        chk("stall_key2_apb", rt_key[64+:32], 32'h5555);
        tick();
        apb_psel = 0; apb_penable = 0;
        chk("stall_pready_end", 32'(apb_pready), 0);

        // APB read coincident with packet write to the same register
        apb_psel = 1; apb_penable = 0; apb_pwrite = 0; apb_paddr = 40'h4C;
        tick();
        apb_penable = 1;
        prx_en = 1; prx_wr = 1; prx_addr = 8'h13; prx_wdata = 32'h77;
        tick();
        prx_en = 0; prx_wr = 0;
        chk("rdwr_pready", 32'(apb_pready), 1);
        chk("rdwr_old", apb_prdata, 0);
        chk("rdwr_key3", rt_key[96+:32], 32'h77);
        tick();
        apb_psel = 0; apb_penable = 0;

        // Packet read held under backpressure, second read dropped
        prx_rrdy = 0; prx_en = 1; prx_wr = 0; prx_addr = 8'h02;
        tick();
        prx_en = 0;
        chk("prd_vld", 32'(prx_rvld), 1);
        chk("prd_data", prx_rdata, 32'hFFFF_FD00);
        prx_en = 1; prx_addr = 8'h01;
        tick();
        prx_en = 0;
        chk("prd_drop", 32'(prx_rd_drop), 1);
        chk("prd_hold", prx_rdata, 32'hFFFF_FD00);
        tick();
        chk("prd_drop_once", 32'(prx_rd_drop), 0);
        chk("prd_vld_held", 32'(prx_rvld), 1);
        prx_rrdy = 1;
        tick();
        prx_rrdy = 0;
        chk("prd_vld_fall", 32'(prx_rvld), 0);
        chk("prd_drops", drops, 1);

        // Read arriving on the accept cycle is taken
        prx_en = 1; prx_addr = 8'h02;
        tick();
        prx_rrdy = 1; prx_addr = 8'h03;
        tick();
        prx_en = 0;
        chk("acc_take_vld", 32'(prx_rvld), 1);
        chk("acc_take_data", prx_rdata, 32);
        chk("acc_take_nodrop", 32'(prx_rd_drop), 0);
        tick();
        prx_rrdy = 0;
        chk("acc_take_done", 32'(prx_rvld), 0);

        // Saturation
        pkt_wr(8'h40, 32'hFFFF_FFFE);
        chk("ctr0_pre", reg_ctr[0+:32], 32'hFFFF_FFFE);
        ctr_cnt = 8'h01;
        tick();
        chk("ctr0_inc", reg_ctr[0+:32], 32'hFFFF_FFFF);
        tick();
        tick();
        ctr_cnt = 0;
        chk("ctr0_sat", reg_ctr[0+:32], 32'hFFFF_FFFF);

        // Packet write beats increment; APB write beats increment
        ctr_cnt = 8'h02;
        pkt_wr(8'h41, 100);
        chk("ctr1_pkt_prio", reg_ctr[32+:32], 100);
        tick();
        chk("ctr1_inc", reg_ctr[32+:32], 101);
        apb(1, 40'h104, 7, rd, err, lat);
        ctr_cnt = 0;
        chk("ctr1_apb_prio", reg_ctr[32+:32], 8);

        // Clear-on-read with coincident increment
        pkt_wr(8'h42, 5);
        apb_psel = 1; apb_penable = 0; apb_pwrite = 0; apb_paddr = 40'h108;
        tick();
        apb_penable = 1; ctr_cnt = 8'h04;
        tick();
        ctr_cnt = 0;
        chk("cor_pready", 32'(apb_pready), 1);
        chk("cor_prdata", apb_prdata, 5);
        chk("cor_ctr2", reg_ctr[64+:32], 1);
        tick();
        apb_psel = 0; apb_penable = 0;
        apb(0, 40'h108, 0, rd, err, lat);
        chk("cor_rd2", rd, 1);
        chk("cor_ctr2_clr", reg_ctr[64+:32], 0);
        chk("cor_ctr0_kept", reg_ctr[0+:32], 32'hFFFF_FFFF);

        // Reset mid-reply and mid-transfer
        prx_en = 1; prx_wr = 0; prx_addr = 8'h01;
        tick();
        prx_en = 0;
        chk("abort_vld_pre", 32'(prx_rvld), 1);
        apb_psel = 1; apb_penable = 0; apb_pwrite = 0; apb_paddr = 40'h104;
        tick();
        apb_penable = 1;
        #2 resetn = 0;
        tick();
        chk("abort_pready", 32'(apb_pready), 0);
        chk("abort_vld", 32'(prx_rvld), 0);
        chk("abort_mpkey", mp_key, 0);
        chk("abort_ctr0", reg_ctr[0+:32], 0);
        apb_psel = 0; apb_penable = 0;
        tick();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_abort_pready", 32'(apb_pready), 0);
            chk("post_abort_vld", 32'(prx_rvld), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
